// File: rtl/ntt_stage_controller_if.sv
// Handshake and address bus between the NTT stage controller and its surroundings.
// The controller side uses the slave modport; whoever requests transforms uses master.
interface ntt_stage_controller_if #(
    parameter int NUM_BU  = 8,
    parameter int COEF_AW = 8
);
    logic                      start;
    logic                      is_ntt_req;
    logic                      hold;
    logic                      busy;
    logic                      done;
    logic [7:0]                len;
    logic                      is_NTT;
    logic [2:0]                layer;
    logic [3:0]                zeta_ofs;
    logic                      bu_valid;
    logic [NUM_BU*COEF_AW-1:0] addr_top;
    logic [NUM_BU*COEF_AW-1:0] addr_bot;

    modport master (
        output start, is_ntt_req, hold,
        input  busy, done, len, is_NTT, layer, zeta_ofs, bu_valid, addr_top, addr_bot
    );

    modport slave (
        input  start, is_ntt_req, hold,
        output busy, done, len, is_NTT, layer, zeta_ofs, bu_valid, addr_top, addr_bot
    );
endinterface

// File: rtl/ntt_stage_controller.sv
// Layer sequencer for the 8-BU NTT/INTT datapath: walks len through 7 layers, issues
// 16 batches of butterfly address pairs per layer and drains the BU pipeline in between.
module ntt_stage_controller #(
    parameter int NUM_BU     = 8,
    parameter int COEF_AW    = 8,
    parameter int BU_LATENCY = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    ntt_stage_controller_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam int DW = $clog2(BU_LATENCY + 2);
    localparam int AW = NUM_BU * COEF_AW;

    state_t             state_q, state_d;
    logic [3:0]         k_q, k_d;
    logic [2:0]         layer_q, layer_d;
    logic [2:0]         s_q, s_d;
    logic [7:0]         len_q, len_d;
    logic               is_ntt_q, is_ntt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               bu_valid_q, bu_valid_d;
    logic [3:0]         zeta_ofs_q, zeta_ofs_d;
    logic [DW-1:0]      drain_q, drain_d;
    logic [AW-1:0]      addr_top_q, addr_top_d;
    logic [AW-1:0]      addr_bot_q, addr_bot_d;

    logic [AW-1:0]      batch_top, batch_bot;
    logic [3:0]         batch_zeta;
    logic [COEF_AW-1:0] b_v, top_v, len_ext;

    // Addresses and zeta offset of batch k in the current layer (s = log2(len)).
    always_comb begin
        batch_top = '0;
        batch_bot = '0;
        b_v       = '0;
        top_v     = '0;
        len_ext   = COEF_AW'(len_q);
        for (int i = 0; i < NUM_BU; i++) begin
            b_v   = COEF_AW'({3'(i), k_q});
            top_v = ((b_v >> s_q) << ({1'b0, s_q} + 4'd1)) | (b_v & (len_ext - COEF_AW'(1)));
            batch_top[i*COEF_AW +: COEF_AW] = top_v;
            batch_bot[i*COEF_AW +: COEF_AW] = top_v + len_ext;
        end
        batch_zeta = k_q >> (is_ntt_q ? {1'b0, s_q} : (4'd8 - {1'b0, s_q}));
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        layer_d    = layer_q;
        s_d        = s_q;
        len_d      = len_q;
        is_ntt_d   = is_ntt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        bu_valid_d = 1'b0;
        zeta_ofs_d = zeta_ofs_q;
        drain_d    = drain_q;
        addr_top_d = addr_top_q;
        addr_bot_d = addr_bot_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    state_d  = ISSUE;
                    is_ntt_d = bus.is_ntt_req;
                    layer_d  = '0;
                    k_d      = '0;
                    len_d    = bus.is_ntt_req ? 8'd128 : 8'd2;
                    s_d      = bus.is_ntt_req ? 3'd7 : 3'd1;
                    busy_d   = 1'b1;
                end
            end
            ISSUE: begin
                if (!bus.hold) begin
                    bu_valid_d = 1'b1;
                    addr_top_d = batch_top;
                    addr_bot_d = batch_bot;
                    zeta_ofs_d = batch_zeta;
                    k_d        = k_q + 4'd1;
                    if (k_q == 4'd15) begin
                        state_d = DRAIN;
                        drain_d = '0;
                    end
                end
            end
            DRAIN: begin
                // DONE takes the slot the next layer's first batch would use, so the last drain is one cycle longer.
                if (layer_q != 3'd6) begin
                    if (drain_q == DW'(BU_LATENCY - 1)) begin
                        state_d = ISSUE;
                        layer_d = layer_q + 3'd1;
                        k_d     = '0;
                        if (is_ntt_q) begin
                            len_d = len_q >> 1;
                            s_d   = s_q - 3'd1;
                        end else begin
                            len_d = len_q << 1;
                            s_d   = s_q + 3'd1;
                        end
                    end else begin
                        drain_d = drain_q + DW'(1);
                    end
                end else if (drain_q == DW'(BU_LATENCY)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            k_q        <= '0;
            layer_q    <= '0;
            s_q        <= '0;
            len_q      <= '0;
            is_ntt_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bu_valid_q <= 1'b0;
            zeta_ofs_q <= '0;
            drain_q    <= '0;
            addr_top_q <= '0;
            addr_bot_q <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            layer_q    <= layer_d;
            s_q        <= s_d;
            len_q      <= len_d;
            is_ntt_q   <= is_ntt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bu_valid_q <= bu_valid_d;
            zeta_ofs_q <= zeta_ofs_d;
            drain_q    <= drain_d;
            addr_top_q <= addr_top_d;
            addr_bot_q <= addr_bot_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.len      = len_q;
    assign bus.is_NTT   = is_ntt_q;
    assign bus.layer    = layer_q;
    assign bus.zeta_ofs = zeta_ofs_q;
    assign bus.bu_valid = bu_valid_q;
    assign bus.addr_top = addr_top_q;
    assign bus.addr_bot = addr_bot_q;
endmodule

// File: tb/tb_ntt_stage_controller.sv
// Scoreboard bench for ntt_stage_controller: expected batches are queued when a run is
// requested and compared as the controller issues them, alongside timing checks.
module tb_ntt_stage_controller;
    localparam int NUM_BU     = 8;
    localparam int COEF_AW    = 8;
    localparam int BU_LATENCY = 4;

    typedef struct packed {
        logic [63:0] top;
        logic [63:0] bot;
        logic [3:0]  zeta;
        logic [7:0]  len;
        logic [2:0]  layer;
        logic        is_ntt;
    } batch_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   valid_cnt;
    int   done_cnt;
    batch_t exp_q[$];
    batch_t last_exp;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ntt_stage_controller_if #(.NUM_BU(NUM_BU), .COEF_AW(COEF_AW)) bus();

    ntt_stage_controller #(
        .NUM_BU(NUM_BU),
        .COEF_AW(COEF_AW),
        .BU_LATENCY(BU_LATENCY)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Reference batches from the group/position view of the butterfly index.
    task automatic pushRun(input logic ntt);
        int len_v;
        len_v = ntt ? 128 : 2;
        for (int lay = 0; lay < 7; lay++) begin
            for (int k = 0; k < 16; k++) begin
                batch_t b;
                b        = '0;
                b.len    = 8'(len_v);
                b.layer  = 3'(lay);
                b.is_ntt = ntt;
                b.zeta   = 4'(ntt ? k / len_v : k / (256 / len_v));
                for (int i = 0; i < NUM_BU; i++) begin
                    int j;
                    int t;
                    j = 16 * i + k;
                    t = (j / len_v) * 2 * len_v + (j % len_v);
                    b.top[i*8 +: 8] = 8'(t);
                    b.bot[i*8 +: 8] = 8'(t + len_v);
                end
                exp_q.push_back(b);
            end
            len_v = ntt ? len_v / 2 : len_v * 2;
        end
    endtask

    task automatic sampleOutputs();
        if (bus.bu_valid === 1'b1) begin
            valid_cnt++;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_batch", 64'd1, 64'd0);
            end else begin
                batch_t e;
                e = exp_q.pop_front();
                last_exp = e;
                checkOutput("addr_top", bus.addr_top, e.top);
                checkOutput("addr_bot", bus.addr_bot, e.bot);
                checkOutput("zeta_ofs", 64'(bus.zeta_ofs), 64'(e.zeta));
                checkOutput("len", 64'(bus.len), 64'(e.len));
                checkOutput("layer", 64'(bus.layer), 64'(e.layer));
                checkOutput("is_NTT", 64'(bus.is_NTT), 64'(e.is_ntt));
            end
        end
        if (bus.done === 1'b1) done_cnt++;
    endtask

    task automatic checkAllZero(input string pfx);
        checkOutput({pfx, "_busy"}, 64'(bus.busy), 64'd0);
        checkOutput({pfx, "_done"}, 64'(bus.done), 64'd0);
        checkOutput({pfx, "_len"}, 64'(bus.len), 64'd0);
        checkOutput({pfx, "_is_NTT"}, 64'(bus.is_NTT), 64'd0);
        checkOutput({pfx, "_layer"}, 64'(bus.layer), 64'd0);
        checkOutput({pfx, "_zeta_ofs"}, 64'(bus.zeta_ofs), 64'd0);
        checkOutput({pfx, "_bu_valid"}, 64'(bus.bu_valid), 64'd0);
        checkOutput({pfx, "_addr_top"}, bus.addr_top, 64'd0);
        checkOutput({pfx, "_addr_bot"}, bus.addr_bot, 64'd0);
    endtask

    // mode 0 plain, 1 hold in ISSUE and DRAIN, 2 start pulse while busy,
    // 3 start held for two back-to-back runs, 4 reset during layer 3.
    task automatic applyStimulus(input logic ntt, input int mode);
        int t0;
        int rel;
        int first_done;
        int second_done;
        valid_cnt   = 0;
        done_cnt    = 0;
        first_done  = -1;
        second_done = -1;
        pushRun(ntt);
        if (mode == 3) pushRun(ntt);
        bus.is_ntt_req = ntt;
        bus.start      = 1'b1;
        @(negedge clk);
        sampleOutputs();
        t0  = cyc;
        rel = 0;
        if (mode != 3) bus.start = 1'b0;
        while (rel < 400) begin
            bus.hold = (mode == 1) && ((rel >= 16 && rel <= 19) || (rel >= 44 && rel <= 46));
            if (mode == 2) bus.start = (rel == 30 || rel == 31);
            rst_n = !(mode == 4 && rel == 70);
            @(negedge clk);
            sampleOutputs();
            rel = cyc - t0;
            if (mode == 1 && rel >= 45 && rel <= 47) begin
                checkOutput("hold_bubble", 64'(bus.bu_valid), 64'd0);
                checkOutput("hold_frozen_top", bus.addr_top, last_exp.top);
                checkOutput("hold_frozen_bot", bus.addr_bot, last_exp.bot);
            end
            if (bus.done === 1'b1) begin
                checkOutput("busy_at_done", 64'(bus.busy), 64'd1);
                if (first_done < 0) first_done = rel;
                else if (second_done < 0) second_done = rel;
            end
            if (mode == 3 && rel == 142) checkOutput("idle_gap_busy", 64'(bus.busy), 64'd0);
            if (mode == 3 && rel == 143) checkOutput("restart_busy", 64'(bus.busy), 64'd1);
            if (mode == 4 && rel == 71) begin
                checkAllZero("abort");
                exp_q.delete();
            end
            if (mode == 4 && rel >= 200) break;
            if (mode == 3 ? (second_done >= 0) : (mode != 4 && first_done >= 0)) break;
        end
        bus.hold = 1'b0;
        rst_n    = 1'b1;
        if (mode == 4) begin
            checkOutput("abort_no_done", 64'(done_cnt), 64'd0);
            checkOutput("abort_idle_busy", 64'(bus.busy), 64'd0);
        end else begin
            checkOutput("done_cycle", 64'(first_done), (mode == 1) ? 64'd144 : 64'd141);
            if (mode == 3) checkOutput("done_cycle_2", 64'(second_done), 64'd284);
            @(negedge clk);
            sampleOutputs();
            bus.start = 1'b0;
            checkOutput("valid_cycles", 64'(valid_cnt), (mode == 3) ? 64'd224 : 64'd112);
            checkOutput("done_pulses", 64'(done_cnt), (mode == 3) ? 64'd2 : 64'd1);
            checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
            checkOutput("busy_after", 64'(bus.busy), 64'd0);
            checkOutput("len_hold", 64'(bus.len), ntt ? 64'd2 : 64'd128);
            checkOutput("is_NTT_hold", 64'(bus.is_NTT), 64'(ntt));
        end
        @(negedge clk);
        sampleOutputs();
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.is_ntt_req = 1'b0;
        bus.hold       = 1'b0;
        rst_n          = 1'b0;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(1'b1, 0);
        applyStimulus(1'b0, 0);
        applyStimulus(1'b1, 1);
        applyStimulus(1'b1, 4);
        applyStimulus(1'b1, 0);
        applyStimulus(1'b1, 2);
        applyStimulus(1'b0, 3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
